// File: rtl/fsa_bank_ctl_if.sv
// ---------------------------------------------------------------------------
// fsa_bank_ctl_if
// AXI4-Stream beat bus between fsa_bank_ctl and its downstream consumer.
//   tvalid  beat valid (master -> slave)
//   tdata   bank word, DW bits (master -> slave)
//   tuser   first beat of a frame (master -> slave)
//   tlast   last beat of a frame (master -> slave)
//   tready  downstream ready (slave -> master)
// ---------------------------------------------------------------------------
interface fsa_bank_ctl_if #(
    parameter int unsigned DW = 32
) ();
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          tuser;
    logic          tlast;
    logic          tready;

    modport master (output tvalid, output tdata, output tuser, output tlast, input tready);
    modport slave  (input tvalid, input tdata, input tuser, input tlast, output tready);
endinterface

// File: rtl/fsa_bank_ctl.sv
// ---------------------------------------------------------------------------
// fsa_bank_ctl
// Owns the BR_NUM column-result banks written by fsa_core. The write bank is
// rotated at every frame-complete pulse (sof); completed banks are queued and
// streamed out in write order, one word per column, then freed.
//
// Ports
//   clk          clock
//   resetn       synchronous active-low reset
//   width        columns per frame, latched when a bank read starts
//   sof          fsa_core frame-complete pulse
//   wr_bmp       one-hot write-bank select to fsa_core (registered)
//   rd_bank_en   one-hot BRAM read enable, high on read-issue cycles only
//   rd_addr      BRAM read address (column)
//   rd_data_all  bank read data, bank i at [i*BR_DW +: BR_DW], latency 1
//   m_axis       AXI4-Stream master (tvalid/tdata/tuser/tlast/tready)
//   frm_drop     1-cycle pulse: frame overwritten because no bank was free
//
// Optional: define FSA_BANK_STAT_EN to add drop_cnt[15:0] (saturating count
// of frm_drop pulses) and frm_cnt[15:0] (wrapping count of accepted tlast).
// ---------------------------------------------------------------------------
module fsa_bank_ctl #(
    parameter int unsigned BR_NUM   = 4,
    parameter int unsigned BR_AW    = 12,
    parameter int unsigned BR_DW    = 32,
    parameter int unsigned C_IMG_WW = 12
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [C_IMG_WW-1:0]     width,
    input  logic                    sof,
    output logic [BR_NUM-1:0]       wr_bmp,
    output logic [BR_NUM-1:0]       rd_bank_en,
    output logic [BR_AW-1:0]        rd_addr,
    input  logic [BR_NUM*BR_DW-1:0] rd_data_all,
    fsa_bank_ctl_if.master          m_axis,
    output logic                    frm_drop
`ifdef FSA_BANK_STAT_EN
    ,
    output logic [15:0]             drop_cnt,
    output logic [15:0]             frm_cnt
`endif
);

    localparam int unsigned IW = (BR_NUM > 1) ? $clog2(BR_NUM) : 1;
    localparam int unsigned CW = (C_IMG_WW > BR_AW) ? C_IMG_WW : BR_AW;

    typedef enum logic [1:0] {BkFree, BkWr, BkFull, BkRd} bank_e;
    typedef enum logic [1:0] {StIdle, StRun, StDrain} rd_st_e;

    bank_e               bank_st [BR_NUM];
    logic [IW-1:0]       wr_idx;
    logic [IW-1:0]       rd_idx;
    rd_st_e              rd_st;
    logic [C_IMG_WW-1:0] w_l;
    logic [BR_AW-1:0]    col;

    // One read in flight: issued last cycle, data arrives on rd_data_all now.
    logic                infl;
    logic                infl_user;
    logic                infl_last;

    // Second FIFO entry; the first entry is the m_axis output register itself.
    logic                sk_v;
    logic [BR_DW-1:0]    sk_data;
    logic                sk_user;
    logic                sk_last;

    logic                pop;
    logic [1:0]          occ;
    logic [2:0]          lvl;
    logic                issue;
    logic                last_col;
    logic                rel;
    logic [IW-1:0]       wr_nxt;
    logic [IW-1:0]       rd_nxt;
    logic                nxt_free;
    logic [BR_DW-1:0]    rd_word;

    always_comb begin
        pop      = m_axis.tvalid & m_axis.tready;
        occ      = {1'b0, m_axis.tvalid} + {1'b0, sk_v};
        // Occupancy after this cycle's pop, counting the read still in flight.
        lvl      = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
        last_col = (CW'(col) == CW'(w_l - 1'b1));
        issue    = (rd_st == StRun) && (w_l != '0) && (occ != 2'd2) && (lvl < 3'd2);
        rel      = ((rd_st == StDrain) && pop && m_axis.tlast) ||
                   ((rd_st == StRun) && (w_l == '0));
        wr_nxt   = (wr_idx == IW'(BR_NUM - 1)) ? '0 : wr_idx + 1'b1;
        rd_nxt   = (rd_idx == IW'(BR_NUM - 1)) ? '0 : rd_idx + 1'b1;
        // A bank released on this edge is already free for allocation.
        nxt_free = (bank_st[wr_nxt] == BkFree) || (rel && (rd_idx == wr_nxt));

        rd_word = '0;
        for (int i = 0; i < BR_NUM; i++) begin
            if (rd_idx == IW'(i)) begin
                rd_word = rd_data_all[i*BR_DW +: BR_DW];
            end
        end

        rd_bank_en = '0;
        if (issue) begin
            rd_bank_en[rd_idx] = 1'b1;
        end
    end

    assign rd_addr = col;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < BR_NUM; i++) begin
                bank_st[i] <= (i == 0) ? BkWr : BkFree;
            end
            wr_idx        <= '0;
            rd_idx        <= '0;
            wr_bmp        <= BR_NUM'(1);
            frm_drop      <= 1'b0;
            rd_st         <= StIdle;
            w_l           <= '0;
            col           <= '0;
            infl          <= 1'b0;
            infl_user     <= 1'b0;
            infl_last     <= 1'b0;
            sk_v          <= 1'b0;
            sk_data       <= '0;
            sk_user       <= 1'b0;
            sk_last       <= 1'b0;
            m_axis.tvalid <= 1'b0;
            m_axis.tdata  <= '0;
            m_axis.tuser  <= 1'b0;
            m_axis.tlast  <= 1'b0;
`ifdef FSA_BANK_STAT_EN
            drop_cnt      <= '0;
            frm_cnt       <= '0;
`endif
        end else begin
            frm_drop <= 1'b0;

            // Reader FSM. Bank updates here precede the writer's so that a
            // same-edge allocation of a just-released bank overrides FREE.
            unique case (rd_st)
                StIdle: begin
                    if (bank_st[rd_idx] == BkFull) begin
                        bank_st[rd_idx] <= BkRd;
                        w_l             <= width;
                        col             <= '0;
                        rd_st           <= StRun;
                    end
                end
                StRun: begin
                    if (w_l == '0) begin
                        bank_st[rd_idx] <= BkFree;
                        rd_idx          <= rd_nxt;
                        rd_st           <= StIdle;
                    end else if (issue) begin
                        col <= col + 1'b1;
                        if (last_col) begin
                            rd_st <= StDrain;
                        end
                    end
                end
                StDrain: begin
                    if (rel) begin
                        bank_st[rd_idx] <= BkFree;
                        rd_idx          <= rd_nxt;
                        rd_st           <= StIdle;
                    end
                end
                default: rd_st <= StIdle;
            endcase

            infl <= issue;
            if (issue) begin
                infl_user <= (col == '0);
                infl_last <= last_col;
            end

            // Two-entry FIFO: output register plus skid entry.
            if (!m_axis.tvalid || pop) begin
                if (sk_v) begin
                    m_axis.tvalid <= 1'b1;
                    m_axis.tdata  <= sk_data;
                    m_axis.tuser  <= sk_user;
                    m_axis.tlast  <= sk_last;
                    sk_v          <= infl;
                    if (infl) begin
                        sk_data <= rd_word;
                        sk_user <= infl_user;
                        sk_last <= infl_last;
                    end
                end else if (infl) begin
                    m_axis.tvalid <= 1'b1;
                    m_axis.tdata  <= rd_word;
                    m_axis.tuser  <= infl_user;
                    m_axis.tlast  <= infl_last;
                end else begin
                    m_axis.tvalid <= 1'b0;
                end
            end else if (infl) begin
                sk_v    <= 1'b1;
                sk_data <= rd_word;
                sk_user <= infl_user;
                sk_last <= infl_last;
            end

            // Write rotation.
            if (sof) begin
                if (nxt_free) begin
                    bank_st[wr_idx] <= BkFull;
                    bank_st[wr_nxt] <= BkWr;
                    wr_idx          <= wr_nxt;
                    wr_bmp          <= BR_NUM'(1) << wr_nxt;
                end else begin
                    frm_drop <= 1'b1;
                end
            end

`ifdef FSA_BANK_STAT_EN
            if (sof && !nxt_free && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
            if (pop && m_axis.tlast) begin
                frm_cnt <= frm_cnt + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_fsa_bank_ctl.sv
// ---------------------------------------------------------------------------
// tb_fsa_bank_ctl
// Table-driven single-frame vectors plus hand-written sequences for bank
// exhaustion, same-edge release/allocation, zero-width frames and reset
// mid-stream. The BRAM model returns {4'hA, bank, 12'h000, addr}.
// ---------------------------------------------------------------------------
module tb_fsa_bank_ctl;

    localparam int unsigned BR_NUM   = 4;
    localparam int unsigned BR_AW    = 12;
    localparam int unsigned BR_DW    = 32;
    localparam int unsigned C_IMG_WW = 12;

    logic                    clk = 1'b0;
    logic                    resetn;
    logic [C_IMG_WW-1:0]     width;
    logic                    sof;
    logic [BR_NUM-1:0]       wr_bmp;
    logic [BR_NUM-1:0]       rd_bank_en;
    logic [BR_AW-1:0]        rd_addr;
    logic [BR_NUM*BR_DW-1:0] rd_data_all = '0;
    logic                    frm_drop;
`ifdef FSA_BANK_STAT_EN
    logic [15:0]             drop_cnt;
    logic [15:0]             frm_cnt;
`endif

    fsa_bank_ctl_if #(.DW(BR_DW)) m_axis ();

    fsa_bank_ctl #(
        .BR_NUM   (BR_NUM),
        .BR_AW    (BR_AW),
        .BR_DW    (BR_DW),
        .C_IMG_WW (C_IMG_WW)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .width       (width),
        .sof         (sof),
        .wr_bmp      (wr_bmp),
        .rd_bank_en  (rd_bank_en),
        .rd_addr     (rd_addr),
        .rd_data_all (rd_data_all),
        .m_axis      (m_axis),
        .frm_drop    (frm_drop)
`ifdef FSA_BANK_STAT_EN
        ,
        .drop_cnt    (drop_cnt),
        .frm_cnt     (frm_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input int b, input int a);
        return {4'hA, 4'(b), 12'h000, 12'(a)};
    endfunction

    // BRAM model, read latency 1.
    always @(posedge clk) begin
        for (int i = 0; i < BR_NUM; i++) begin
            if (rd_bank_en[i]) begin
                rd_data_all[i*BR_DW +: BR_DW] <= word(i, int'(rd_addr));
            end
        end
    end

    typedef struct {
        logic [31:0] d;
        logic        u;
        logic        l;
    } beat_t;

    beat_t       beats[$];
    int          tlast_seen = 0;
    int          drop_seen  = 0;
    int          stab_err   = 0;
    int          full_err   = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_d     = '0;
    logic        prev_u     = 1'b0;
    logic        prev_l     = 1'b0;
    int          iss_nm1    = 0;
    int          iss_nm2    = 0;
    int          acc        = 0;

    // Monitor: accepted beats, stall stability, issue-while-full, drops.
    always @(negedge clk) begin
        if (!resetn) begin
            prev_stall <= 1'b0;
            iss_nm1    <= 0;
            iss_nm2    <= 0;
            acc        <= 0;
        end else begin
            if (prev_stall && (!m_axis.tvalid || m_axis.tdata !== prev_d ||
                               m_axis.tuser !== prev_u || m_axis.tlast !== prev_l)) begin
                stab_err <= stab_err + 1;
            end
            prev_stall <= m_axis.tvalid && !m_axis.tready;
            prev_d     <= m_axis.tdata;
            prev_u     <= m_axis.tuser;
            prev_l     <= m_axis.tlast;
            // iss_nm2 - acc is the number of words held in the DUT output FIFO.
            if (((|rd_bank_en) && (iss_nm2 - acc) >= 2) || (iss_nm2 - acc) > 2 ||
                (iss_nm2 - acc) < 0 || $countones(rd_bank_en) > 1) begin
                full_err <= full_err + 1;
            end
            iss_nm2 <= iss_nm1;
            iss_nm1 <= iss_nm1 + ((|rd_bank_en) ? 1 : 0);
            if (m_axis.tvalid && m_axis.tready) begin
                acc <= acc + 1;
                beats.push_back('{d: m_axis.tdata, u: m_axis.tuser, l: m_axis.tlast});
                if (m_axis.tlast) begin
                    tlast_seen <= tlast_seen + 1;
                end
            end
            if (frm_drop) begin
                drop_seen <= drop_seen + 1;
            end
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        sof           = 1'b0;
        width         = '0;
        m_axis.tready = 1'b1;
        repeat (3) tick();
        resetn = 1'b1;
    endtask

    typedef struct {
        int          w;
        bit          tog;
        int          exp_n;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        logic [3:0]  exp_bmp;
    } vec_t;

    vec_t vecs[4];

    initial begin
        int          base;
        int          tl0;
        int          got;
        bit          found;
        beat_t       b;
        logic [3:0]  exp_c[4];

        resetn        = 1'b0;
        sof           = 1'b0;
        width         = '0;
        m_axis.tready = 1'b0;

        vecs[0] = '{w: 4, tog: 1'b0, exp_n: 4, exp_first: 32'hA000_0000,
                    exp_last: 32'hA000_0003, exp_bmp: 4'b0010};
        vecs[1] = '{w: 8, tog: 1'b1, exp_n: 8, exp_first: 32'hA000_0000,
                    exp_last: 32'hA000_0007, exp_bmp: 4'b0010};
        vecs[2] = '{w: 1, tog: 1'b0, exp_n: 1, exp_first: 32'hA000_0000,
                    exp_last: 32'hA000_0000, exp_bmp: 4'b0010};
        vecs[3] = '{w: 0, tog: 1'b0, exp_n: 0, exp_first: 32'h0,
                    exp_last: 32'h0, exp_bmp: 4'b0010};

        // ---- table: one frame per vector from reset ----
        for (int vi = 0; vi < 4; vi++) begin
            do_reset();
            check($sformatf("v%0d_rst_bmp", vi), 64'(wr_bmp), 64'h1);
            check($sformatf("v%0d_rst_tvalid", vi), 64'(m_axis.tvalid), 64'h0);
            check($sformatf("v%0d_rst_rden", vi), 64'(rd_bank_en), 64'h0);
            check($sformatf("v%0d_rst_addr", vi), 64'(rd_addr), 64'h0);
            check($sformatf("v%0d_rst_drop", vi), 64'(frm_drop), 64'h0);

            width = 12'(vecs[vi].w);
            base  = beats.size();
            tl0   = tlast_seen;
            sof   = 1'b1;
            tick();
            sof = 1'b0;
            check($sformatf("v%0d_bmp_after_sof", vi), 64'(wr_bmp), 64'(vecs[vi].exp_bmp));

            if (vecs[vi].exp_n > 0) begin
                for (int c = 0; c < 300 && tlast_seen == tl0; c++) begin
                    if (vecs[vi].tog) m_axis.tready = ~m_axis.tready;
                    tick();
                end
            end else begin
                repeat (10) tick();
            end
            m_axis.tready = 1'b1;
            repeat (4) tick();

            got = beats.size() - base;
            check($sformatf("v%0d_frames", vi), 64'(tlast_seen - tl0),
                  (vecs[vi].exp_n > 0) ? 64'h1 : 64'h0);
            check($sformatf("v%0d_nbeats", vi), 64'(got), 64'(vecs[vi].exp_n));
            if (got >= vecs[vi].exp_n && vecs[vi].exp_n > 0) begin
                for (int k = 0; k < vecs[vi].exp_n; k++) begin
                    b = beats[base + k];
                    check($sformatf("v%0d_beat%0d", vi, k), {30'h0, b.u, b.l, b.d},
                          {30'h0, 1'(k == 0), 1'(k == vecs[vi].exp_n - 1), word(0, k)});
                end
                check($sformatf("v%0d_first", vi), 64'(beats[base].d), 64'(vecs[vi].exp_first));
                check($sformatf("v%0d_last", vi), 64'(beats[base + vecs[vi].exp_n - 1].d),
                      64'(vecs[vi].exp_last));
            end
        end

        // ---- bank exhaustion: tready=0, four sofs ----
        do_reset();
        m_axis.tready = 1'b0;
        width         = 12'd4;
        base          = beats.size();
        for (int s = 0; s < 3; s++) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            check($sformatf("exh_bmp%0d", s), 64'(wr_bmp), 64'(4'b0010 << s));
            repeat (2) tick();
        end
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check("exh_drop_pulse", 64'(frm_drop), 64'h1);
        check("exh_bmp_held", 64'(wr_bmp), 64'h8);
`ifdef FSA_BANK_STAT_EN
        check("exh_drop_cnt", 64'(drop_cnt), 64'h1);
`endif
        tick();
        check("exh_drop_end", 64'(frm_drop), 64'h0);
        check("exh_stall_head", {29'h0, m_axis.tvalid, m_axis.tuser, m_axis.tlast, m_axis.tdata},
              {29'h0, 1'b1, 1'b1, 1'b0, 32'hA000_0000});

        // ---- sof on the edge that accepts bank0's tlast ----
        m_axis.tready = 1'b1;
        found         = 1'b0;
        for (int c = 0; c < 50; c++) begin
            if (m_axis.tvalid && m_axis.tlast) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("rel_found_tlast", 64'(found), 64'h1);
        sof = 1'b1;
        tick();
        sof = 1'b0;
        check("rel_bmp", 64'(wr_bmp), 64'h1);
        check("rel_no_drop", 64'(frm_drop), 64'h0);
        repeat (80) tick();
        got = beats.size() - base;
        check("rel_nbeats", 64'(got), 64'd16);
        if (got >= 16) begin
            for (int k = 0; k < 16; k++) begin
                b = beats[base + k];
                check($sformatf("rel_beat%0d", k), {30'h0, b.u, b.l, b.d},
                      {30'h0, 1'((k % 4) == 0), 1'((k % 4) == 3), word(k / 4, k % 4)});
            end
        end
`ifdef FSA_BANK_STAT_EN
        check("rel_frm_cnt", 64'(frm_cnt), 64'd4);
`endif

        // ---- width=0 frames: back-to-back sofs never run out of banks ----
        do_reset();
        m_axis.tready = 1'b0;
        width         = '0;
        base          = beats.size();
        exp_c[0] = 4'b0010;
        exp_c[1] = 4'b0100;
        exp_c[2] = 4'b1000;
        exp_c[3] = 4'b0001;
        sof = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            check($sformatf("w0_bmp%0d", s), 64'(wr_bmp), 64'(exp_c[s]));
        end
        sof = 1'b0;
        check("w0_no_drop", 64'(frm_drop), 64'h0);
        m_axis.tready = 1'b1;
        repeat (10) tick();
        check("w0_no_beats", 64'(beats.size() - base), 64'h0);

        // ---- reset mid-frame, then a clean 3-beat frame ----
        do_reset();
        m_axis.tready = 1'b0;
        width         = 12'd8;
        sof           = 1'b1;
        tick();
        sof = 1'b0;
        repeat (6) tick();
        m_axis.tready = 1'b1;
        repeat (2) tick();
        resetn = 1'b0;
        tick();
        check("mid_rst_tvalid", 64'(m_axis.tvalid), 64'h0);
        check("mid_rst_bmp", 64'(wr_bmp), 64'h1);
        tick();
        resetn = 1'b1;
        width  = 12'd3;
        base   = beats.size();
        tl0    = tlast_seen;
        sof    = 1'b1;
        tick();
        sof = 1'b0;
        for (int c = 0; c < 100 && tlast_seen == tl0; c++) tick();
        repeat (4) tick();
        got = beats.size() - base;
        check("post_rst_nbeats", 64'(got), 64'd3);
        if (got >= 3) begin
            for (int k = 0; k < 3; k++) begin
                b = beats[base + k];
                check($sformatf("post_rst_beat%0d", k), {30'h0, b.u, b.l, b.d},
                      {30'h0, 1'(k == 0), 1'(k == 2), word(0, k)});
            end
        end

        // ---- global monitor results ----
        check("stall_stable", 64'(stab_err), 64'h0);
        check("no_issue_when_full", 64'(full_err), 64'h0);
        check("drop_pulses_total", 64'(drop_seen), 64'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
